// File: rtl/loop_uhat_sparse_pkg.sv
// Shared widths and the tag record carried alongside the loop_uhat_sparse multiplier.
package loop_uhat_sparse_pkg;

    localparam int unsigned VAL_W   = 13;
    localparam int unsigned X_W     = 71;
    localparam int unsigned ACC_W   = 71;
    localparam int unsigned ROW_W   = 16;
    localparam int unsigned MUL_LAT = 4;

    typedef struct packed {
        logic             vld;
        logic             last;
        logic [ROW_W-1:0] row;
    } tag_t;

endpackage

// File: rtl/loop_uhat_sparse_tag_pipe.sv
// Tag delay line matched to the multiplier latency; the tail lines up with mul_dout.
module loop_uhat_sparse_tag_pipe
    import loop_uhat_sparse_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  tag_t in_tag,
    output tag_t tail,
    output logic any_vld
);

    tag_t stage_q [MUL_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else if (ce) begin
            stage_q[0] <= in_tag;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tail = stage_q[MUL_LAT-1];

    always_comb begin
        any_vld = 1'b0;
        for (int unsigned i = 0; i < MUL_LAT; i++) begin
            any_vld = any_vld | stage_q[i].vld;
        end
    end

endmodule

// File: rtl/loop_uhat_sparse_row_acc.sv
// Feeds the external pipelined multiplier and sums its products per sparse row,
// presenting one row sum with a sticky signed-overflow flag on a valid/ready port.
module loop_uhat_sparse_row_acc
    import loop_uhat_sparse_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] in_val,
    input  logic [X_W-1:0]   in_x,
    input  logic [ROW_W-1:0] in_row,
    input  logic             in_last,
    output logic             mul_ce,
    output logic [VAL_W-1:0] mul_din0,
    output logic [X_W-1:0]   mul_din1,
    input  logic [ACC_W-1:0] mul_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [ROW_W-1:0] out_row,
    output logic             out_ovf,
    output logic             idle
);

    logic             ce;
    tag_t             in_tag;
    tag_t             tail;
    logic             any_vld;
    logic [ACC_W-1:0] acc_q;
    logic             row_ovf_q;
    logic             row_open_q;
    logic [ACC_W-1:0] sum;
    logic             ovf_now;

    // A held result freezes the whole pipeline, multiplier included.
    assign ce       = !out_valid || out_ready;
    assign in_ready = ce;
    assign mul_ce   = ce;
    assign mul_din0 = in_val;
    assign mul_din1 = in_x;

    always_comb begin
        in_tag      = '0;
        in_tag.vld  = in_valid && ce;
        in_tag.last = in_last;
        in_tag.row  = in_row;
    end

    loop_uhat_sparse_tag_pipe u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .in_tag  (in_tag),
        .tail    (tail),
        .any_vld (any_vld)
    );

    assign sum     = acc_q + mul_dout;
    assign ovf_now = (acc_q[ACC_W-1] == mul_dout[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            row_ovf_q  <= 1'b0;
            row_open_q <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_ovf    <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (ce && tail.vld) begin
                if (tail.last) begin
                    out_data   <= sum;
                    out_row    <= tail.row;
                    out_ovf    <= row_ovf_q | ovf_now;
                    out_valid  <= 1'b1;
                    acc_q      <= '0;
                    row_ovf_q  <= 1'b0;
                    row_open_q <= 1'b0;
                end else begin
                    acc_q      <= sum;
                    row_ovf_q  <= row_ovf_q | ovf_now;
                    row_open_q <= 1'b1;
                end
            end
        end
    end

    assign idle = !any_vld && !row_open_q && !out_valid;

endmodule

// File: tb/tb_loop_uhat_sparse_row_acc.sv
// Directed bench for loop_uhat_sparse_row_acc with a behavioural 4-stage ce-enabled multiplier.
module tb_loop_uhat_sparse_row_acc;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic signed [12:0]  in_val;
    logic signed [70:0]  in_x;
    logic [15:0]         in_row;
    logic                in_last;
    logic                mul_ce;
    logic [12:0]         mul_din0;
    logic [70:0]         mul_din1;
    logic [70:0]         mul_dout;
    logic                out_valid;
    logic                out_ready;
    logic [70:0]         out_data;
    logic [15:0]         out_row;
    logic                out_ovf;
    logic                idle;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic signed [12:0] val;
        logic signed [70:0] x;
        logic [15:0]        row;
        logic               last;
        logic [70:0]        exp_data;
        logic               exp_ovf;
    } vec_t;

    typedef struct {
        logic [70:0] data;
        logic [15:0] row;
        logic        ovf;
        int          cyc;
    } res_t;

    vec_t vecs [$];
    vec_t exps [$];
    res_t got  [$];

    always #5 clk = ~clk;

    loop_uhat_sparse_row_acc dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_val    (in_val),
        .in_x      (in_x),
        .in_row    (in_row),
        .in_last   (in_last),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_ovf   (out_ovf),
        .idle      (idle)
    );

    // Stand-in for the external multiplier: 13s x 71s -> 71, four ce-enabled stages.
    logic signed [70:0] mp [4];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mul_ce) begin
            mp[0] <= $signed(mul_din0) * $signed(mul_din1);
            for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
        end
    end
    assign mul_dout = mp[3];

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got.push_back('{data: out_data, row: out_row, ovf: out_ovf, cyc: cyc});
        end
    end

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic signed [12:0] v, input logic signed [70:0] x,
                                input logic [15:0] r, input logic l,
                                input logic [70:0] ed, input logic eo);
        vec_t t;
        t.val = v; t.x = x; t.row = r; t.last = l; t.exp_data = ed; t.exp_ovf = eo;
        return t;
    endfunction

    // Present one entry (starting just after a rising edge) and return just after its accept edge.
    task automatic send(input logic signed [12:0] v, input logic signed [70:0] x,
                        input logic [15:0] r, input logic l);
        int k = 0;
        in_valid = 1'b1; in_val = v; in_x = x; in_row = r; in_last = l;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            failures++;
            checks++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input int n);
        int k = 0;
        while (got.size() < n && k < 80) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("result_count", 71'(got.size()), 71'(n));
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat;
        reset = 1'b1; in_valid = 1'b0; in_val = '0; in_x = '0; in_row = '0; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        check("reset_out_valid", 71'(out_valid), 71'd0);
        check("reset_out_data",  out_data, 71'd0);
        check("reset_out_row",   71'(out_row), 71'd0);
        check("reset_out_ovf",   71'(out_ovf), 71'd0);
        check("reset_idle",      71'(idle), 71'd1);
        check("reset_in_ready",  71'(in_ready), 71'd1);
        @(posedge clk);
        #1;

        // Latency: single-entry row, count edges from the accept edge to out_valid.
        send(13'sd5, 71'sd5, 16'd4, 1'b1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency_edges", 71'(lat), 71'd5);
        wait_res(1);
        if (got.size() >= 1) check("latency_data", got[0].data, 71'd25);
        got.delete();

        // Dense table-driven stream.
        vecs.push_back(mk(13'sd2,  71'sd10, 16'd3, 1'b0, 71'd0, 1'b0));
        vecs.push_back(mk(-13'sd3, 71'sd5,  16'd3, 1'b0, 71'd0, 1'b0));
        vecs.push_back(mk(13'sd4,  -71'sd1, 16'd3, 1'b1, 71'd1, 1'b0));
        vecs.push_back(mk(13'sd7,  71'sd6,  16'd0, 1'b1, 71'd42, 1'b0));
        vecs.push_back(mk(-13'sd1, 71'sd100, 16'd1, 1'b1, -71'sd100, 1'b0));
        vecs.push_back(mk(13'sd1,  (71'sd1 <<< 69), 16'd5, 1'b0, 71'd0, 1'b0));
        vecs.push_back(mk(13'sd1,  (71'sd1 <<< 69), 16'd5, 1'b1, (71'd1 << 70), 1'b1));
        vecs.push_back(mk(13'sd1,  71'sd3,  16'd6, 1'b1, 71'd3, 1'b0));
        vecs.push_back(mk(-13'sd4096, 71'sd1, 16'd9, 1'b1, -71'sd4096, 1'b0));
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].val, vecs[i].x, vecs[i].row, vecs[i].last);
            if (vecs[i].last) exps.push_back(vecs[i]);
        end
        in_valid = 1'b0;
        wait_res(exps.size());
        for (int i = 0; i < exps.size() && i < got.size(); i++) begin
            check($sformatf("table_data[%0d]", i), got[i].data, exps[i].exp_data);
            check($sformatf("table_row[%0d]", i),  71'(got[i].row), 71'(exps[i].row));
            check($sformatf("table_ovf[%0d]", i),  71'(got[i].ovf), 71'(exps[i].exp_ovf));
        end
        if (got.size() >= 3) check("b2b_consecutive", 71'(got[2].cyc - got[1].cyc), 71'd1);
        got.delete();
        idle_cycles(2);

        // Backpressure: two single-entry rows while the consumer is not ready.
        out_ready = 1'b0;
        send(13'sd5, 71'sd5, 16'd10, 1'b1);
        send(13'sd6, 71'sd6, 16'd11, 1'b1);
        idle_cycles(10);
        check("stall_out_valid", 71'(out_valid), 71'd1);
        check("stall_out_data",  out_data, 71'd25);
        check("stall_in_ready",  71'(in_ready), 71'd0);
        check("stall_mul_ce",    71'(mul_ce), 71'd0);
        check("stall_idle",      71'(idle), 71'd0);
        check("stall_no_pop",    71'(got.size()), 71'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("pulse_out_valid", 71'(out_valid), 71'd1);
        check("pulse_out_data",  out_data, 71'd36);
        check("pulse_out_row",   71'(out_row), 71'd11);
        idle_cycles(3);
        out_ready = 1'b1;
        wait_res(2);
        idle_cycles(3);
        check("stall_total", 71'(got.size()), 71'd2);
        if (got.size() >= 2) begin
            check("stall_first",  got[0].data, 71'd25);
            check("stall_second", got[1].data, 71'd36);
        end
        got.delete();

        // Reset mid-row discards the partial sum and in-flight entries.
        send(13'sd9, 71'sd9, 16'd2, 1'b0);
        send(13'sd9, 71'sd9, 16'd2, 1'b0);
        idle_cycles(1);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("midreset_idle", 71'(idle), 71'd1);
        @(posedge clk);
        #1;
        send(13'sd1, 71'sd5, 16'd2, 1'b1);
        in_valid = 1'b0;
        wait_res(1);
        if (got.size() >= 1) begin
            check("midreset_data", got[0].data, 71'd5);
            check("midreset_row",  71'(got[0].row), 71'd2);
        end
        got.delete();
        idle_cycles(2);

        // Bubbles between entries give the same sum as the dense case.
        send(13'sd1, 71'sd1, 16'd7, 1'b0);
        in_valid = 1'b0;
        check("bubble_busy", 71'(idle), 71'd0);
        idle_cycles(1);
        send(13'sd2, 71'sd2, 16'd7, 1'b0);
        idle_cycles(1);
        send(13'sd3, 71'sd3, 16'd7, 1'b1);
        in_valid = 1'b0;
        wait_res(1);
        if (got.size() >= 1) begin
            check("bubble_data", got[0].data, 71'd14);
            check("bubble_row",  71'(got[0].row), 71'd7);
        end
        idle_cycles(1);
        check("bubble_idle_after", 71'(idle), 71'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
